stream_nasti_mover_arbiter: RTL

Round-robin scheduler that shares one stream-to-NASTI data mover between `N_REQ` DMA requesters. It latches a granted descriptor (address, length) and drives the mover's `w_valid`/`w_addr`/`w_len` command port. It holds the command until the mover's one-cycle `w_ready` completion, then returns a one-cycle done pulse to the owning requester. It exports the current grant so an external stream mux can route that requester's data stream into the mover's `src` channel. Zero-beat descriptors complete locally and never reach the mover.

---
 rtl/stream_nasti_mover_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/stream_nasti_mover_arbiter.sv
// Round-robin scheduler that shares one stream-to-NASTI data mover between N_REQ requesters.
// It latches the winning descriptor, drives the mover command and returns a one-cycle completion pulse.
module stream_nasti_mover_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_len,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          w_valid,
  output logic [ADDR_WIDTH-1:0]         w_addr,
  output logic [ADDR_WIDTH-1:0]         w_len,
  input  logic                          w_ready,
  output logic [N_REQ-1:0]              grant,
  output logic [$clog2(N_REQ)-1:0]      grant_idx,
  output logic                          busy
);

  localparam int IDX_W      = $clog2(N_REQ);
  localparam int ADDR_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, ISSUE, SKIP, DONE} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        last;
  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [N_REQ-1:0]        win_onehot;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [ADDR_WIDTH-1:0]   win_len;
  logic                    win_zero;

  // (base + off) mod N_REQ, with off in 1..N_REQ
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!win_found && req_valid[rr_idx(last, off)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(last, off);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = req_len[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  // Fewer bytes than one beat: nothing for the mover to do
  assign win_zero   = (win_len >> ADDR_SHIFT) == '0;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      last      <= IDX_W'(N_REQ - 1);
      w_valid   <= 1'b0;
      w_addr    <= '0;
      w_len     <= '0;
      req_ready <= '0;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= '0;
          if (win_found) begin
            grant     <= win_onehot;
            grant_idx <= win_idx;
            last      <= win_idx;
            w_addr    <= win_addr;
            w_len     <= win_len;
            busy      <= 1'b1;
            if (win_zero) begin
              state <= SKIP;
            end else begin
              w_valid <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Drop w_valid together with the completion so the mover never sees a repeat command
          if (w_ready) begin
            w_valid   <= 1'b0;
            req_ready <= grant;
            state     <= DONE;
          end
        end
        SKIP: begin
          req_ready <= grant;
          state     <= DONE;
        end
        DONE: begin
          req_ready <= '0;
          grant     <= '0;
          grant_idx <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
